// File: rtl/tx_egress_collector_pkg.sv
// Shared egress-chain parameters: frame field widths and the capture FSM encoding.
package tx_egress_collector_pkg;

   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned PORT_NUB_TOTAL  = 4;
   localparam int unsigned DATA_LENGTH_MAX = 7;
   localparam int unsigned PRIORITY        = 4;
   localparam int unsigned CRC32_LENGTH    = 32;

   localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
   localparam int unsigned WIDTH_PORT     = DATA_WIDTH + WIDTH_SEL;
   localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX + 1);
   localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY);
   localparam int unsigned WIDTH_CRC      = $clog2(CRC32_LENGTH);
   // Header LEN field sits just above the CRC and priority fields.
   localparam int unsigned LEN_LSB        = WIDTH_CRC + WIDTH_PRIORITY;

   typedef logic [WIDTH_LENGTH-1:0] len_t;

   typedef enum logic [0:0] {
      StIdle,
      StBody
   } cap_state_e;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with free count and a registered almost-full flag.
module sync_fwft_fifo #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AFULL_TH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     free,
   output logic                       almost_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count, count_next, free_next;
   logic             wr_en, rd_en, almost_full_q;

   assign count       = wr_ptr_q - rd_ptr_q;
   assign full        = (count == (AW+1)'(DEPTH));
   assign empty       = (count == '0);
   assign free        = (AW+1)'(DEPTH) - count;
   assign wr_en       = push & ~full;
   assign rd_en       = pop & ~empty;
   assign count_next  = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
   assign free_next   = (AW+1)'(DEPTH) - count_next;
   // Head is gated so the output reads 0 while nothing valid is stored.
   assign rdata       = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
   assign almost_full = almost_full_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         almost_full_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         almost_full_q <= (free_next < (AW+1)'(AFULL_TH));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/tx_egress_collector.sv
// Egress collector: captures frames for port NUB into a FIFO for the MAC, forwards the rest.
module tx_egress_collector
   import tx_egress_collector_pkg::*;
#(
   parameter int unsigned NUB        = 0,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned KEEP_TH    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH_PORT-1:0]     data_in,
   input  logic [WIDTH_SEL-1:0]      nub_in,
   input  logic                      valid_in,
   input  logic [PORT_NUB_TOTAL-1:0] done_in,
   output logic                      keep_out,
   input  logic                      keep_in,
   output logic [WIDTH_PORT-1:0]     data_out,
   output logic [WIDTH_SEL-1:0]      nub_out,
   output logic                      valid_out,
   output logic [DATA_WIDTH-1:0]     mac_data,
   output logic                      mac_valid,
   output logic                      mac_last,
   input  logic                      mac_ready,
   output logic                      err_flag
);

   cap_state_e                state_q;
   len_t                      cnt_q;
   logic                      err_q;
   logic [WIDTH_PORT-1:0]     fwd_data_q;
   logic [WIDTH_SEL-1:0]      fwd_nub_q;
   logic                      fwd_valid_q;

   logic [WIDTH_SEL-1:0]      dest;
   logic                      is_dest, match, push_last, done_nub;
   len_t                      hdr_len;
   logic                      fifo_full, fifo_empty, fifo_afull;
   logic [DATA_WIDTH:0]       fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_free;
   logic                      unused_ok;

   assign dest      = data_in[WIDTH_PORT-1 -: WIDTH_SEL];
   assign is_dest   = (dest == WIDTH_SEL'(NUB));
   assign keep_out  = keep_in | fifo_afull;
   assign match     = valid_in & is_dest & ~keep_out;
   assign hdr_len   = data_in[LEN_LSB +: WIDTH_LENGTH];
   assign done_nub  = done_in[NUB];
   assign push_last = (state_q == StIdle) ? (hdr_len == '0) : (cnt_q == len_t'(1));
   // Other ports' done pulses and the free count are not needed here.
   assign unused_ok = ^{done_in, fifo_free};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (match && fifo_full) err_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (match) begin
                  cnt_q <= hdr_len;
                  if (hdr_len != '0) state_q <= StBody;
               end
            end
            StBody: begin
               // Early done truncates the frame; the stored partial frame has no last marker.
               if (done_nub) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (match) begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == len_t'(1)) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_data_q  <= '0;
         fwd_nub_q   <= '0;
         fwd_valid_q <= 1'b0;
      end else if (!keep_in) begin
         fwd_data_q  <= data_in;
         fwd_nub_q   <= nub_in;
         fwd_valid_q <= valid_in & ~is_dest;
      end
   end

   sync_fwft_fifo #(
      .WIDTH    (DATA_WIDTH + 1),
      .DEPTH    (FIFO_DEPTH),
      .AFULL_TH (KEEP_TH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (match),
      .wdata       ({push_last, data_in[DATA_WIDTH-1:0]}),
      .pop         (mac_ready),
      .rdata       (fifo_rdata),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .free        (fifo_free),
      .almost_full (fifo_afull)
   );

   assign mac_valid = ~fifo_empty;
   assign mac_data  = fifo_rdata[DATA_WIDTH-1:0];
   assign mac_last  = fifo_rdata[DATA_WIDTH];
   assign data_out  = fwd_data_q;
   assign nub_out   = fwd_nub_q;
   assign valid_out = fwd_valid_q;
   assign err_flag  = err_q;

endmodule

// File: tb/tb_tx_egress_collector.sv
// Randomized bench for tx_egress_collector against a queue-based frame model.
module tb_tx_egress_collector;
   import tx_egress_collector_pkg::*;

   localparam int unsigned NUB        = 2;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned KEEP_TH    = 2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [WIDTH_PORT-1:0]     data_in = '0;
   logic [WIDTH_SEL-1:0]      nub_in = '0;
   logic                      valid_in = 1'b0;
   logic [PORT_NUB_TOTAL-1:0] done_in = '0;
   logic                      keep_out;
   logic                      keep_in = 1'b0;
   logic [WIDTH_PORT-1:0]     data_out;
   logic [WIDTH_SEL-1:0]      nub_out;
   logic                      valid_out;
   logic [DATA_WIDTH-1:0]     mac_data;
   logic                      mac_valid, mac_last;
   logic                      mac_ready = 1'b0;
   logic                      err_flag;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DATA_WIDTH:0]   mq[$];
   bit                    m_af, m_err, m_in_frame;
   int                    m_rem;
   logic                  m_fv;
   logic [WIDTH_SEL-1:0]  m_fn;
   logic [WIDTH_PORT-1:0] m_fd;

   tx_egress_collector #(
      .NUB        (NUB),
      .FIFO_DEPTH (FIFO_DEPTH),
      .KEEP_TH    (KEEP_TH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .nub_in    (nub_in),
      .valid_in  (valid_in),
      .done_in   (done_in),
      .keep_out  (keep_out),
      .keep_in   (keep_in),
      .data_out  (data_out),
      .nub_out   (nub_out),
      .valid_out (valid_out),
      .mac_data  (mac_data),
      .mac_valid (mac_valid),
      .mac_last  (mac_last),
      .mac_ready (mac_ready),
      .err_flag  (err_flag)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_af = 0; m_err = 0; m_in_frame = 0; m_rem = 0;
      m_fv = 0; m_fn = '0; m_fd = '0;
   endtask

   // Called right after a falling edge with this cycle's inputs applied.
   task automatic tick(output bit consumed);
      bit exp_keep, is_nub, m, done_err;
      int occ;
      logic [DATA_WIDTH:0] w;
      #1;
      exp_keep = keep_in | m_af;
      check_eq("keep_out", keep_out, exp_keep);
      check_eq("mac_valid", mac_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         check_eq("mac_data", mac_data, mq[0][DATA_WIDTH-1:0]);
         check_eq("mac_last", mac_last, mq[0][DATA_WIDTH]);
      end
      check_eq("valid_out", valid_out, m_fv);
      check_eq("data_out", data_out, m_fd);
      check_eq("nub_out", nub_out, m_fn);
      check_eq("err_flag", err_flag, m_err);

      occ      = mq.size();
      is_nub   = valid_in && (data_in[WIDTH_PORT-1 -: WIDTH_SEL] == WIDTH_SEL'(NUB));
      m        = is_nub && !exp_keep;
      done_err = done_in[NUB] && m_in_frame;
      if (mac_ready && occ != 0) void'(mq.pop_front());
      if (m) begin
         w[DATA_WIDTH-1:0] = data_in[DATA_WIDTH-1:0];
         if (!m_in_frame) begin
            m_rem            = int'(data_in[LEN_LSB +: WIDTH_LENGTH]);
            w[DATA_WIDTH]    = (m_rem == 0);
            m_in_frame       = (m_rem != 0);
         end else begin
            w[DATA_WIDTH] = (m_rem == 1);
            m_rem--;
            if (m_rem == 0) m_in_frame = 0;
         end
         if (occ == int'(FIFO_DEPTH)) m_err = 1;
         else mq.push_back(w);
      end
      if (done_err) begin
         m_err = 1; m_in_frame = 0; m_rem = 0;
      end
      m_af = (int'(FIFO_DEPTH) - mq.size()) < int'(KEEP_TH);
      if (!keep_in) begin
         m_fv = valid_in && !is_nub;
         m_fn = nub_in;
         m_fd = data_in;
      end
      consumed = !exp_keep;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      valid_in = 0;
      for (int i = 0; i < n; i++) tick(acc);
   endtask

   task automatic send(input logic [WIDTH_SEL-1:0] dest, input logic [DATA_WIDTH-1:0] pl,
                       input bit rnd);
      bit acc;
      int n;
      acc = 0; n = 0;
      valid_in = 1;
      data_in  = {dest, pl};
      nub_in   = WIDTH_SEL'($urandom);
      while (!acc && n < 200) begin
         if (rnd) begin
            mac_ready = ($urandom_range(0, 3) != 0);
            keep_in   = ($urandom_range(0, 7) == 0);
         end
         tick(acc);
         n++;
      end
      check_eq("send_accepted", acc, 1'b1);
      valid_in = 0;
   endtask

   function automatic logic [WIDTH_SEL-1:0] other_dest();
      int d;
      d = $urandom_range(0, PORT_NUB_TOTAL - 2);
      if (d >= int'(NUB)) d++;
      return WIDTH_SEL'(d);
   endfunction

   task automatic send_frame(input int len, input bit rnd, input bit mix);
      logic [DATA_WIDTH-1:0] pl;
      for (int i = 0; i <= len; i++) begin
         if (mix) send(other_dest(), $urandom, rnd);
         pl = $urandom;
         if (i == 0) pl[LEN_LSB +: WIDTH_LENGTH] = WIDTH_LENGTH'(len);
         send(WIDTH_SEL'(NUB), pl, rnd);
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      valid_in = 0; keep_in = 0; mac_ready = 1;
      while (mq.size() != 0 && n < 100) begin
         tick(acc);
         n++;
      end
      check_eq("drain_mac_valid", mac_valid, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 0; keep_in = 0; valid_in = 0; done_in = '0; mac_ready = 0;
      #1;
      check_eq("rst_mac_valid", mac_valid, 1'b0);
      check_eq("rst_mac_data", mac_data, '0);
      check_eq("rst_mac_last", mac_last, 1'b0);
      check_eq("rst_valid_out", valid_out, 1'b0);
      check_eq("rst_data_out", data_out, '0);
      check_eq("rst_nub_out", nub_out, '0);
      check_eq("rst_keep_out", keep_out, 1'b0);
      check_eq("rst_err_flag", err_flag, 1'b0);
      model_clear();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      logic [DATA_WIDTH-1:0] pl;
      #1;
      do_reset();

      // LEN=3 frame with MAC always ready
      mac_ready = 1;
      send_frame(3, 0, 0);
      drain();

      // forwarded words interleaved with a captured frame
      send_frame(4, 0, 1);
      idle(1);
      drain();

      // MAC stalled: seven words fill to the keep threshold without a drop
      mac_ready = 0;
      send_frame(6, 0, 0);
      valid_in = 0;
      #1;
      check_eq("bp_keep_out", keep_out, 1'b1);
      check_eq("bp_err_flag", err_flag, 1'b0);
      @(negedge clk);
      drain();

      // zero-length frame followed by a normal one; done for NUB in idle is benign
      send_frame(0, 0, 0);
      done_in[NUB] = 1'b1;
      idle(1);
      done_in = '0;
      send_frame(2, 0, 0);
      drain();

      // randomized traffic
      for (int f = 0; f < 40; f++) begin
         send_frame($urandom_range(0, DATA_LENGTH_MAX), 1, $urandom_range(0, 1) == 1);
         done_in = PORT_NUB_TOTAL'($urandom) & ~(PORT_NUB_TOTAL'(1) << NUB);
         if ($urandom_range(0, 1) == 1) done_in[NUB] = 1'b1;
         idle($urandom_range(1, 2));
         done_in = '0;
      end
      drain();

      // early done mid-frame: sticky error, next header still captured
      pl = $urandom;
      pl[LEN_LSB +: WIDTH_LENGTH] = WIDTH_LENGTH'(4);
      send(WIDTH_SEL'(NUB), pl, 0);
      send(WIDTH_SEL'(NUB), $urandom, 0);
      done_in[NUB] = 1'b1;
      idle(1);
      done_in = '0;
      check_eq("done_err_flag", err_flag, 1'b1);
      send_frame(2, 0, 0);
      drain();

      // downstream hold: forward register frozen, keep_out asserted
      send(WIDTH_SEL'(1), $urandom, 0);
      keep_in = 1;
      for (int i = 0; i < 5; i++) begin
         valid_in = 1;
         data_in  = {WIDTH_SEL'(1), DATA_WIDTH'($urandom)};
         nub_in   = WIDTH_SEL'($urandom);
         tick(acc);
      end
      valid_in = 0;
      keep_in = 0;
      idle(1);

      // reset in the middle of a frame discards it
      mac_ready = 0;
      pl = $urandom;
      pl[LEN_LSB +: WIDTH_LENGTH] = WIDTH_LENGTH'(5);
      send(WIDTH_SEL'(NUB), pl, 0);
      send(WIDTH_SEL'(NUB), $urandom, 0);
      send(WIDTH_SEL'(NUB), $urandom, 0);
      do_reset();
      send_frame(1, 0, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
